// File: rtl/axis_checker_pkg.sv
// Shared constants and types for the multi-channel AXI4-Stream checker.
// Error codes are bit indices within each channel's 5-bit error group.
package axis_checker_pkg;

    localparam int ERR_VALID_DROP   = 0;
    localparam int ERR_PAYLOAD_CHG  = 1;
    localparam int ERR_STRB_NO_KEEP = 2;
    localparam int ERR_RESET_EXIT   = 3;
    localparam int ERR_STALL        = 4;
    localparam int N_ERR            = 5;

    typedef logic [N_ERR-1:0] err_vec_t;

endpackage

// File: rtl/axis_multi_protocol_checker_if.sv
// Packed multi-channel AXI4-Stream bundle, channel 0 in the LSBs.
// The checker attaches through the passive monitor modport.
interface axis_multi_protocol_checker_if #(
    parameter int NUM_CH     = 2,
    parameter int BYTE_WIDTH = 4,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);

    logic [NUM_CH-1:0]              tvalid;
    logic [NUM_CH-1:0]              tready;
    logic [NUM_CH*8*BYTE_WIDTH-1:0] tdata;
    logic [NUM_CH*BYTE_WIDTH-1:0]   tstrb;
    logic [NUM_CH*BYTE_WIDTH-1:0]   tkeep;
    logic [NUM_CH-1:0]              tlast;
    logic [NUM_CH*ID_WIDTH-1:0]     tid;
    logic [NUM_CH*DEST_WIDTH-1:0]   tdest;
    logic [NUM_CH*USER_WIDTH-1:0]   tuser;

    modport master (
        output tvalid, tdata, tstrb, tkeep,
        output tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep,
        input  tlast, tid, tdest, tuser,
        output tready
    );

    modport monitor (
        input tvalid, tready, tdata, tstrb,
        input tkeep, tlast, tid, tdest, tuser
    );

endinterface

// File: rtl/axis_checker_lane.sv
// One monitored AXI4-Stream channel: checks, sticky flags, statistics.
// AXIS_CHECKER_FORMAL_EN adds immediate asserts on every per-cycle check.
module axis_checker_lane
    import axis_checker_pkg::*;
#(
    parameter int BYTE_WIDTH = 4,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    parameter int MAX_STALL  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    tvalid,
    input  logic                    tready,
    input  logic [8*BYTE_WIDTH-1:0] tdata,
    input  logic [BYTE_WIDTH-1:0]   tstrb,
    input  logic [BYTE_WIDTH-1:0]   tkeep,
    input  logic                    tlast,
    input  logic [ID_WIDTH-1:0]     tid,
    input  logic [DEST_WIDTH-1:0]   tdest,
    input  logic [USER_WIDTH-1:0]   tuser,
    output err_vec_t                err_now,
    output err_vec_t                err_flags,
    output logic [CNT_WIDTH-1:0]    beat_cnt,
    output logic [CNT_WIDTH-1:0]    pkt_cnt,
    output logic [CNT_WIDTH-1:0]    byte_cnt
);

    localparam int PW  = 10*BYTE_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
    localparam int KW  = $clog2(BYTE_WIDTH + 1);
    localparam int SUW = ((CNT_WIDTH > KW) ? CNT_WIDTH : KW) + 1;
    localparam logic [SUW-1:0] CMAX = SUW'({CNT_WIDTH{1'b1}});

    logic [PW-1:0]  pay;
    logic [PW-1:0]  prev_pay;
    logic           prev_valid;
    logic           prev_ready;
    logic           first_cyc;
    logic           stalled;
    logic           beat;
    logic           stall_hit;
    logic [KW-1:0]  keep_bytes;
    logic [SUW-1:0] byte_sum;

    assign pay     = {tdata, tstrb, tkeep, tlast, tid, tdest, tuser};
    assign stalled = tvalid && !tready;
    assign beat    = tvalid && tready;

    // Previous-cycle samples; first_cyc marks the cycle right after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_cyc  <= 1'b1;
            prev_valid <= 1'b0;
            prev_ready <= 1'b0;
            prev_pay   <= '0;
        end else begin
            first_cyc  <= 1'b0;
            prev_valid <= tvalid;
            prev_ready <= tready;
            prev_pay   <= pay;
        end
    end

    generate
        if (MAX_STALL > 0) begin : g_stall
            localparam int SW = $clog2(MAX_STALL + 1);
            localparam logic [SW-1:0] SMAX = SW'(MAX_STALL);
            logic [SW-1:0] stall_cnt;

            // Saturating stall length; restarts on any non-stall cycle.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stall_cnt <= '0;
                end else if (!stalled) begin
                    stall_cnt <= '0;
                end else if (stall_cnt != SMAX) begin
                    stall_cnt <= stall_cnt + SW'(1);
                end
            end

            // Fires only on the cycle the count reaches the limit.
            assign stall_hit = stalled && (stall_cnt == SMAX - SW'(1));
        end else begin : g_no_stall
            assign stall_hit = 1'b0;
        end
    endgenerate

    // Per-cycle violation detection.
    always_comb begin
        err_now = '0;
        err_now[ERR_VALID_DROP] = !first_cyc && prev_valid &&
                                  !prev_ready && !tvalid;
        err_now[ERR_PAYLOAD_CHG] = !first_cyc && prev_valid &&
                                   !prev_ready && (pay != prev_pay);
        err_now[ERR_STRB_NO_KEEP] = tvalid && |(tstrb & ~tkeep);
        err_now[ERR_RESET_EXIT] = first_cyc && tvalid;
        err_now[ERR_STALL] = stall_hit;
    end

    // Sticky flags; a same-cycle error survives clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_flags <= '0;
        end else if (clear) begin
            err_flags <= err_now;
        end else begin
            err_flags <= err_flags | err_now;
        end
    end

    // Number of kept bytes in the current beat.
    always_comb begin
        keep_bytes = '0;
        for (int b = 0; b < BYTE_WIDTH; b++) begin
            keep_bytes = keep_bytes + KW'(tkeep[b]);
        end
    end

    assign byte_sum = SUW'(byte_cnt) + SUW'(keep_bytes);

    // Saturating statistics, advanced on handshakes only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
            pkt_cnt  <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
            pkt_cnt  <= '0;
            byte_cnt <= '0;
        end else if (beat) begin
            if (beat_cnt != '1) begin
                beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            end
            if (tlast && (pkt_cnt != '1)) begin
                pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
            end
            if (byte_sum > CMAX) begin
                byte_cnt <= '1;
            end else begin
                byte_cnt <= byte_sum[CNT_WIDTH-1:0];
            end
        end
    end

`ifdef AXIS_CHECKER_FORMAL_EN
    // Each check as an immediate assertion outside reset.
    always @(posedge clk) begin
        if (!reset) begin
            a_valid_drop: assert (!err_now[ERR_VALID_DROP]);
            a_payload:    assert (!err_now[ERR_PAYLOAD_CHG]);
            a_strb_keep:  assert (!err_now[ERR_STRB_NO_KEEP]);
            a_reset_exit: assert (!err_now[ERR_RESET_EXIT]);
            a_stall:      assert (!err_now[ERR_STALL]);
        end
    end
`endif

endmodule

// File: rtl/axis_multi_protocol_checker.sv
// Passive AXI4-Stream checker for NUM_CH independent channels.
// AXIS_CHECKER_FORMAL_EN enables lane asserts and per-code covers.
module axis_multi_protocol_checker
    import axis_checker_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int BYTE_WIDTH = 4,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    parameter int MAX_STALL  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    axis_multi_protocol_checker_if.monitor bus,
    output logic [NUM_CH*N_ERR-1:0]       err_flags,
    output logic                          err_any,
    output logic                          first_valid,
    output logic [$clog2(NUM_CH):0]       first_ch,
    output logic [2:0]                    first_code,
    output logic [NUM_CH*CNT_WIDTH-1:0]   beat_cnt,
    output logic [NUM_CH*CNT_WIDTH-1:0]   pkt_cnt,
    output logic [NUM_CH*CNT_WIDTH-1:0]   byte_cnt
);

    localparam int CHW = $clog2(NUM_CH) + 1;
    localparam int DW  = 8 * BYTE_WIDTH;

    err_vec_t         lane_now   [NUM_CH];
    err_vec_t         lane_flags [NUM_CH];
    logic             hit;
    logic [CHW-1:0]   hit_ch;
    logic [2:0]       hit_code;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        axis_checker_lane #(
            .BYTE_WIDTH (BYTE_WIDTH),
            .ID_WIDTH   (ID_WIDTH),
            .DEST_WIDTH (DEST_WIDTH),
            .USER_WIDTH (USER_WIDTH),
            .MAX_STALL  (MAX_STALL),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .clear     (clear),
            .tvalid    (bus.tvalid[i]),
            .tready    (bus.tready[i]),
            .tdata     (bus.tdata[i*DW +: DW]),
            .tstrb     (bus.tstrb[i*BYTE_WIDTH +: BYTE_WIDTH]),
            .tkeep     (bus.tkeep[i*BYTE_WIDTH +: BYTE_WIDTH]),
            .tlast     (bus.tlast[i]),
            .tid       (bus.tid[i*ID_WIDTH +: ID_WIDTH]),
            .tdest     (bus.tdest[i*DEST_WIDTH +: DEST_WIDTH]),
            .tuser     (bus.tuser[i*USER_WIDTH +: USER_WIDTH]),
            .err_now   (lane_now[i]),
            .err_flags (lane_flags[i]),
            .beat_cnt  (beat_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
            .pkt_cnt   (pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
            .byte_cnt  (byte_cnt[i*CNT_WIDTH +: CNT_WIDTH])
        );

        assign err_flags[i*N_ERR +: N_ERR] = lane_flags[i];
    end

    assign err_any = |err_flags;

    // Lowest channel, then lowest code, among this cycle's errors.
    always_comb begin
        hit      = 1'b0;
        hit_ch   = '0;
        hit_code = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            for (int e = N_ERR - 1; e >= 0; e--) begin
                if (lane_now[c][e]) begin
                    hit      = 1'b1;
                    hit_ch   = CHW'(c);
                    hit_code = 3'(e);
                end
            end
        end
    end

    // First-error record; a same-cycle error reloads it through clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_valid <= 1'b0;
            first_ch    <= '0;
            first_code  <= '0;
        end else if (clear || (!first_valid && hit)) begin
            first_valid <= hit;
            first_ch    <= hit_ch;
            first_code  <= hit_code;
        end
    end

`ifdef AXIS_CHECKER_FORMAL_EN
    for (genvar e = 0; e < N_ERR; e++) begin : g_cover
        logic code_hit;

        // Any channel raising this code in the current cycle.
        always_comb begin
            code_hit = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                code_hit = code_hit | lane_now[c][e];
            end
        end

        // Reachability of each error code.
        always @(posedge clk) begin
            if (!reset) begin
                c_code: cover (code_hit);
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_multi_protocol_checker.sv
// Scoreboard bench for axis_multi_protocol_checker, two channels.
// A second instance with CNT_WIDTH=4 watches the same bus.
module tb_axis_multi_protocol_checker;

    localparam int K_FLAGS  = 0;
    localparam int K_ANY    = 1;
    localparam int K_FVALID = 2;
    localparam int K_FCH    = 3;
    localparam int K_FCODE  = 4;
    localparam int K_BEAT   = 5;
    localparam int K_PKT    = 6;
    localparam int K_BYTE   = 7;
    localparam int K_BEAT4  = 8;
    localparam int K_BYTE4  = 9;

    logic clk;
    logic reset;
    logic clear;

    logic [9:0]  err_flags, err_flags4;
    logic        err_any, err_any4;
    logic        first_valid, first_valid4;
    logic [1:0]  first_ch, first_ch4;
    logic [2:0]  first_code, first_code4;
    logic [63:0] beat_cnt, pkt_cnt, byte_cnt;
    logic [7:0]  beat_cnt4, pkt_cnt4, byte_cnt4;

    int vectors;
    int miscompares;

    int          kind_q [$];
    logic [63:0] exp_q  [$];
    string       name_q [$];

    axis_multi_protocol_checker_if #(
        .NUM_CH(2), .BYTE_WIDTH(4), .ID_WIDTH(1),
        .DEST_WIDTH(1), .USER_WIDTH(1)
    ) bus ();

    axis_multi_protocol_checker #(
        .NUM_CH(2), .BYTE_WIDTH(4), .ID_WIDTH(1), .DEST_WIDTH(1),
        .USER_WIDTH(1), .MAX_STALL(16), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .bus(bus),
        .err_flags(err_flags), .err_any(err_any),
        .first_valid(first_valid), .first_ch(first_ch),
        .first_code(first_code), .beat_cnt(beat_cnt),
        .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt)
    );

    axis_multi_protocol_checker #(
        .NUM_CH(2), .BYTE_WIDTH(4), .ID_WIDTH(1), .DEST_WIDTH(1),
        .USER_WIDTH(1), .MAX_STALL(16), .CNT_WIDTH(4)
    ) dut4 (
        .clk(clk), .reset(reset), .clear(clear), .bus(bus),
        .err_flags(err_flags4), .err_any(err_any4),
        .first_valid(first_valid4), .first_ch(first_ch4),
        .first_code(first_code4), .beat_cnt(beat_cnt4),
        .pkt_cnt(pkt_cnt4), .byte_cnt(byte_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] actual(int k);
        case (k)
            K_FLAGS:  return 64'(err_flags);
            K_ANY:    return 64'(err_any);
            K_FVALID: return 64'(first_valid);
            K_FCH:    return 64'(first_ch);
            K_FCODE:  return 64'(first_code);
            K_BEAT:   return 64'(beat_cnt[31:0]);
            K_PKT:    return 64'(pkt_cnt[31:0]);
            K_BYTE:   return 64'(byte_cnt[31:0]);
            K_BEAT4:  return 64'(beat_cnt4[3:0]);
            K_BYTE4:  return 64'(byte_cnt4[3:0]);
            default:  return 64'hDEAD;
        endcase
    endfunction

    task automatic want(int k, logic [63:0] e, string n);
        kind_q.push_back(k);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    // Monitor: drains pending expectations on every falling edge.
    initial begin
        int          k;
        logic [63:0] e;
        logic [63:0] a;
        string       n;
        vectors = 0;
        miscompares = 0;
        forever begin
            @(negedge clk);
            while (kind_q.size() > 0) begin
                k = kind_q.pop_front();
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a = actual(k);
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL %s: got %0h, expected %0h", n, a, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.tvalid = 2'b00;
        bus.tready = 2'b11;
        bus.tlast  = 2'b00;
        bus.tkeep  = 8'hFF;
        bus.tstrb  = 8'hFF;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        bus.tdata = 64'h0;
        bus.tid   = 2'b00;
        bus.tdest = 2'b00;
        bus.tuser = 2'b00;
        idle();

        // Reset exit with ch1 valid and ch0 strobing an unkept byte.
        bus.tvalid = 2'b11;
        bus.tkeep  = {4'hF, 4'b0011};
        bus.tstrb  = {4'hF, 4'b0100};
        tick();
        tick();
        want(K_FLAGS, 64'h0, "rst_flags");
        want(K_ANY, 64'h0, "rst_any");
        want(K_FVALID, 64'h0, "rst_fvalid");
        want(K_BEAT, 64'h0, "rst_beat");
        want(K_BYTE, 64'h0, "rst_byte");
        reset = 1'b0;
        tick();
        want(K_FLAGS, 64'h10C, "rexit_flags");
        want(K_ANY, 64'h1, "rexit_any");
        want(K_FVALID, 64'h1, "rexit_fvalid");
        want(K_FCH, 64'h0, "rexit_fch");
        want(K_FCODE, 64'h2, "rexit_fcode");
        want(K_BEAT, 64'h1, "rexit_beat");
        want(K_BYTE, 64'h2, "rexit_byte");
        idle();
        tick();
        do_clear();
        want(K_FLAGS, 64'h0, "clr_flags");
        want(K_ANY, 64'h0, "clr_any");
        want(K_FVALID, 64'h0, "clr_fvalid");
        want(K_BEAT, 64'h0, "clr_beat");
        want(K_BYTE, 64'h0, "clr_byte");

        // VALID_DROP on ch0.
        bus.tvalid[0] = 1'b1;
        bus.tready[0] = 1'b0;
        tick();
        want(K_FLAGS, 64'h0, "drop_pre");
        bus.tvalid[0] = 1'b0;
        bus.tready[0] = 1'b1;
        tick();
        want(K_FLAGS, 64'h001, "drop_flags");
        want(K_FVALID, 64'h1, "drop_fvalid");
        want(K_FCH, 64'h0, "drop_fch");
        want(K_FCODE, 64'h0, "drop_fcode");
        tick();
        want(K_FLAGS, 64'h001, "drop_sticky");
        do_clear();
        want(K_FLAGS, 64'h0, "drop_clr");

        // PAYLOAD_CHG on ch1 mid-stall.
        bus.tvalid[1] = 1'b1;
        bus.tready[1] = 1'b0;
        bus.tdata[63:32] = 32'hA5A5A5A5;
        tick();
        want(K_FLAGS, 64'h0, "pchg_pre");
        bus.tdata[63:32] = 32'h5A5A5A5A;
        tick();
        want(K_FLAGS, 64'h040, "pchg_flags");
        want(K_FCH, 64'h1, "pchg_fch");
        want(K_FCODE, 64'h1, "pchg_fcode");
        bus.tready[1] = 1'b1;
        tick();
        bus.tvalid[1] = 1'b0;
        tick();
        want(K_FLAGS, 64'h040, "pchg_sticky");
        do_clear();

        // STALL on ch0 at the sixteenth stalled cycle.
        bus.tvalid[0] = 1'b1;
        bus.tready[0] = 1'b0;
        repeat (15) tick();
        want(K_FLAGS, 64'h0, "stall_15");
        tick();
        want(K_FLAGS, 64'h010, "stall_16");
        want(K_FCODE, 64'h4, "stall_fcode");
        repeat (4) tick();
        want(K_FLAGS, 64'h010, "stall_20");
        want(K_BEAT, 64'h0, "stall_nobeat");
        bus.tready[0] = 1'b1;
        tick();
        want(K_BEAT, 64'h1, "stall_hs_beat");
        bus.tready[0] = 1'b0;
        do_clear();
        want(K_FLAGS, 64'h0, "restall_clr");
        repeat (14) tick();
        want(K_FLAGS, 64'h0, "restall_15");
        tick();
        want(K_FLAGS, 64'h010, "restall_16");
        bus.tready[0] = 1'b1;
        tick();
        bus.tvalid[0] = 1'b0;
        tick();
        do_clear();

        // Statistics: ten beats, TLAST on beats 5 and 10.
        bus.tvalid[0] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            bus.tlast[0] = (i == 5) || (i == 10);
            tick();
        end
        bus.tvalid[0] = 1'b0;
        bus.tlast[0] = 1'b0;
        tick();
        want(K_BEAT, 64'd10, "stat_beat");
        want(K_PKT, 64'd2, "stat_pkt");
        want(K_BYTE, 64'd40, "stat_byte");
        want(K_BEAT4, 64'd10, "stat_beat4");
        want(K_FLAGS, 64'h0, "stat_flags");
        do_clear();
        want(K_BEAT, 64'd0, "stat_clr_beat");
        want(K_PKT, 64'd0, "stat_clr_pkt");
        want(K_BYTE, 64'd0, "stat_clr_byte");
        bus.tvalid[0] = 1'b1;
        repeat (20) tick();
        bus.tvalid[0] = 1'b0;
        tick();
        want(K_BEAT, 64'd20, "sat_beat32");
        want(K_BEAT4, 64'd15, "sat_beat4");
        want(K_BYTE4, 64'd15, "sat_byte4");
        want(K_BYTE, 64'd80, "sat_byte32");
        do_clear();

        // Clear in the same cycle as a VALID_DROP.
        bus.tvalid[1] = 1'b1;
        bus.tkeep[7:4] = 4'h0;
        bus.tstrb[7:4] = 4'h1;
        tick();
        bus.tvalid[1] = 1'b0;
        bus.tkeep[7:4] = 4'hF;
        bus.tstrb[7:4] = 4'hF;
        tick();
        want(K_FLAGS, 64'h080, "strb1_flags");
        want(K_FCH, 64'h1, "strb1_fch");
        want(K_FCODE, 64'h2, "strb1_fcode");
        bus.tvalid[0] = 1'b1;
        bus.tready[0] = 1'b0;
        tick();
        bus.tvalid[0] = 1'b0;
        bus.tready[0] = 1'b1;
        do_clear();
        want(K_FLAGS, 64'h001, "clrdrop_flags");
        want(K_ANY, 64'h1, "clrdrop_any");
        want(K_FVALID, 64'h1, "clrdrop_fvalid");
        want(K_FCH, 64'h0, "clrdrop_fch");
        want(K_FCODE, 64'h0, "clrdrop_fcode");
        tick();
        want(K_FLAGS, 64'h001, "clrdrop_hold");

        for (int i = 0; i < 20; i++) begin
            if (kind_q.size() == 0) break;
            @(posedge clk);
        end
        if (kind_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d checks pending, expected 0",
                     kind_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
